mem_access_ctrl: RTL

//  Two-port, fixed-latency access controller that sits directly upstream of main_memory.

---
 rtl/mem_access_ctrl.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: two-port fixed-latency access controller placed in front of main_memory.
//
// The instruction port (I, read-only) and data port (D, read/write) share a single combinational
// memory interface. One request is accepted at a time in IDLE. The access then occupies LATENCY
// BUSY cycles, and a one-cycle response pulse goes back to the owning port.
//
// Optional feature: define MEM_ARB_DPRIO_EN for fixed D-over-I priority. When it is undefined
// (the default), the two ports are served round-robin.
//
// Parameters:
//   ADDR_W   address width
//   DATA_W   data width
//   LATENCY  memory access cycles (1..15)
//
// Ports:
//   clk, reset                   clock; synchronous active-high reset
//   i_req, i_addr, i_ready       I-port request / address / accepted this cycle
//   i_rsp_valid, i_rsp_data      I-port response pulse and read data
//   d_req, d_wr, d_addr,
//   d_wdata, d_ready             D-port request / write flag / address / write data / accepted
//   d_rsp_valid, d_rsp_data      D-port response pulse; read data, or 0 on a write ack
//   mem_addr, mem_wdata,
//   mem_wrt_en, mem_rdata        main_memory interface
module mem_access_ctrl #(
    parameter int unsigned ADDR_W  = 20,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned LATENCY = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ready,
    output logic              i_rsp_valid,
    output logic [DATA_W-1:0] i_rsp_data,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic              d_rsp_valid,
    output logic [DATA_W-1:0] d_rsp_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wrt_en,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;
    typedef enum logic {PortI = 1'b0, PortD = 1'b1} port_e;

    localparam logic [3:0] CntInit = 4'(LATENCY - 1);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    port_e             owner_q, owner_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_wrt_en_q, mem_wrt_en_d;
    logic              i_rsp_valid_q, i_rsp_valid_d;
    logic              d_rsp_valid_q, d_rsp_valid_d;
    logic [DATA_W-1:0] i_rsp_data_q, i_rsp_data_d;
    logic [DATA_W-1:0] d_rsp_data_q, d_rsp_data_d;
    logic              grant_i, grant_d;

`ifndef MEM_ARB_DPRIO_EN
    port_e             last_grant_q, last_grant_d;
`endif

    // Arbitration: at most one grant, and only to a requesting port.
    always_comb begin
`ifdef MEM_ARB_DPRIO_EN
        grant_i = i_req & ~d_req;
`else
        // On contention, grant the port that was not served last.
        grant_i = i_req & (~d_req | (last_grant_q == PortD));
`endif
        grant_d = d_req & ~grant_i;
        i_ready = (state_q == StIdle) & grant_i;
        d_ready = (state_q == StIdle) & grant_d;
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        owner_d       = owner_q;
        wr_d          = wr_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        mem_wrt_en_d  = 1'b0;
        i_rsp_valid_d = 1'b0;
        d_rsp_valid_d = 1'b0;
        i_rsp_data_d  = i_rsp_data_q;
        d_rsp_data_d  = d_rsp_data_q;
`ifndef MEM_ARB_DPRIO_EN
        last_grant_d  = last_grant_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (i_ready || d_ready) begin
                    owner_d     = d_ready ? PortD : PortI;
                    wr_d        = d_ready & d_wr;
                    mem_addr_d  = d_ready ? d_addr : i_addr;
                    mem_wdata_d = d_ready ? d_wdata : '0;
                    cnt_d       = CntInit;
                    state_d     = StBusy;
                    // With a single BUSY cycle, that first cycle is already the write cycle.
                    mem_wrt_en_d = d_ready & d_wr & (LATENCY == 1);
`ifndef MEM_ARB_DPRIO_EN
                    last_grant_d = d_ready ? PortD : PortI;
`endif
                end
            end
            StBusy: begin
                if (cnt_q != 4'd0) begin
                    cnt_d        = cnt_q - 4'd1;
                    // Registered strobe lands exactly on the final BUSY cycle.
                    mem_wrt_en_d = wr_q & (cnt_q == 4'd1);
                end else begin
                    if (owner_q == PortD) begin
                        d_rsp_valid_d = 1'b1;
                        d_rsp_data_d  = wr_q ? '0 : mem_rdata;
                    end else begin
                        i_rsp_valid_d = 1'b1;
                        i_rsp_data_d  = mem_rdata;
                    end
                    state_d = StResp;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            cnt_q         <= 4'd0;
            owner_q       <= PortI;
            wr_q          <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            mem_wrt_en_q  <= 1'b0;
            i_rsp_valid_q <= 1'b0;
            d_rsp_valid_q <= 1'b0;
            i_rsp_data_q  <= '0;
            d_rsp_data_q  <= '0;
`ifndef MEM_ARB_DPRIO_EN
            last_grant_q  <= PortD;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            owner_q       <= owner_d;
            wr_q          <= wr_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_wrt_en_q  <= mem_wrt_en_d;
            i_rsp_valid_q <= i_rsp_valid_d;
            d_rsp_valid_q <= d_rsp_valid_d;
            i_rsp_data_q  <= i_rsp_data_d;
            d_rsp_data_q  <= d_rsp_data_d;
`ifndef MEM_ARB_DPRIO_EN
            last_grant_q  <= last_grant_d;
`endif
        end
    end

    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_wrt_en  = mem_wrt_en_q;
    assign i_rsp_valid = i_rsp_valid_q;
    assign d_rsp_valid = d_rsp_valid_q;
    assign i_rsp_data  = i_rsp_data_q;
    assign d_rsp_data  = d_rsp_data_q;

endmodule
